// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one SPI master among NUM_REQ
// requesters. Each grant runs one byte transfer: START strobe, WAIT for the
// rising edge of spi_done (or timeout), then a fixed GAP before re-arbitrating.
module spi_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] tx_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rx_data,
    output logic                 err,
    output logic                 busy,
    output logic                 spi_start,
    output logic [7:0]           spi_data,
    input  logic                 spi_done,
    input  logic [7:0]           spi_rx
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int IDX_W = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_q, rsp_d;
    logic [7:0]           rx_q, rx_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [7:0]           data_q, data_d;
    logic                 done_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    logic                 any_req;
    logic [PTR_W-1:0]     winner;
    logic [7:0]           win_data;
    logic                 done_rise;
    logic                 cnt_at_limit;

    // A spi_done level that was already high before this cycle is not a completion.
    assign done_rise    = spi_done & ~done_q;
    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Round-robin search: first set req bit at or above rr_ptr, wrapping to 0.
    always_comb begin
        logic [IDX_W-1:0] idx;
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        // Walk from the farthest offset down so the nearest candidate wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (req[idx[PTR_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[PTR_W-1:0];
            end
        end
    end

    // Select the winning requester's byte from the packed tx_data bus.
    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_data = tx_data[8*i +: 8];
            end
        end
    end

    // Next-state logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (done_rise || cnt_at_limit) state_d = ST_GAP;
            ST_GAP:   if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output and counter, keyed on the current state.
    always_comb begin
        gnt_d    = gnt_q;
        rsp_d    = '0;
        rx_d     = rx_q;
        err_d    = 1'b0;
        start_d  = 1'b0;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d    = NUM_REQ'(1) << winner;
                    start_d  = 1'b1;
                    data_d   = win_data;
                    rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            ST_START: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                if (!cnt_at_limit) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A done edge on the last allowed cycle still counts as success.
                if (done_rise) begin
                    rsp_d = gnt_q;
                    rx_d  = spi_rx;
                    gnt_d = '0;
                    gap_d = '0;
                end else if (cnt_at_limit) begin
                    rsp_d = gnt_q;
                    rx_d  = 8'h00;
                    err_d = 1'b1;
                    gnt_d = '0;
                    gap_d = '0;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            rsp_q    <= '0;
            rx_q     <= 8'h00;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rsp_q    <= rsp_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            data_q   <= data_d;
            done_q   <= spi_done;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_q;
    assign rx_data   = rx_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign spi_start = start_q;
    assign spi_data  = data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_spi_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TO  = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [8*N-1:0] tx_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rx_data;
    logic           err;
    logic           busy;
    logic           spi_start;
    logic [7:0]     spi_data;
    logic           spi_done;
    logic [7:0]     spi_rx;

    always #5 clk = ~clk;

    spi_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rx_data(rx_data), .err(err),
        .busy(busy), .spi_start(spi_start), .spi_data(spi_data),
        .spi_done(spi_done), .spi_rx(spi_rx)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction owns the master from its start cycle until a done edge or
    // TO waiting cycles; the master is then idle again GAP cycles later.
    int           cyc = 0;
    logic         chk_en = 1'b0;
    logic         m_active = 1'b0;
    int           m_t0 = 0;
    int           m_ready = 0;
    int           m_ptr = 0;
    logic         m_prev_done = 1'b0;
    logic [N-1:0] exp_gnt = '0, exp_rsp = '0;
    logic [7:0]   exp_rx = 8'h00, exp_data = 8'h00;
    logic         exp_err = 1'b0, exp_busy = 1'b0, exp_start = 1'b0;

    always @(posedge clk) begin
        int  w;
        logic ended;
        if (!rst_n) begin
            m_active = 1'b0; m_ptr = 0; m_ready = cyc + 1; m_prev_done = 1'b0;
            exp_gnt = '0; exp_rsp = '0; exp_rx = 8'h00; exp_err = 1'b0;
            exp_busy = 1'b0; exp_start = 1'b0; exp_data = 8'h00;
            chk_en = 1'b1;
        end else begin
            exp_rsp = '0; exp_err = 1'b0; exp_start = 1'b0; ended = 1'b0;
            if (m_active && cyc > m_t0) begin
                if (spi_done && !m_prev_done) begin
                    exp_rsp = exp_gnt; exp_rx = spi_rx; ended = 1'b1;
                end else if (cyc - m_t0 == TO) begin
                    exp_rsp = exp_gnt; exp_rx = 8'h00; exp_err = 1'b1; ended = 1'b1;
                end
                if (ended) begin
                    exp_gnt = '0; m_active = 1'b0; m_ready = cyc + 1 + GAP;
                end
            end else if (!m_active && cyc >= m_ready && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                exp_gnt   = N'(1) << w;
                exp_data  = tx_data[8*w +: 8];
                exp_start = 1'b1;
                m_ptr     = (w + 1) % N;
                m_t0      = cyc + 1;
                m_active  = 1'b1;
            end
            exp_busy    = m_active || (cyc + 1 < m_ready);
            m_prev_done = spi_done;
        end
        cyc++;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("err", 32'(err), 32'(exp_err));
            check("busy", 32'(busy), 32'(exp_busy));
            check("spi_start", 32'(spi_start), 32'(exp_start));
            check("spi_data", 32'(spi_data), 32'(exp_data));
            if (exp_rsp != '0) check("rx_data", 32'(rx_data), 32'(exp_rx));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(output int at);
        int n = 0;
        while (spi_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("start_seen", 32'(spi_start), 32'd1);
        at = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_rsp"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rx"}, 32'(rx_data), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(spi_start), 32'd0);
        check({tag, "_data"}, 32'(spi_data), 32'd0);
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int s_at[5];

    initial begin
        int s, r, n;
        req = '0; tx_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        spi_done = 1'b0; spi_rx = 8'h00; rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single request from requester 2.
        req = 4'b0100;
        tick();
        check("single_start", 32'(spi_start), 32'd1);
        check("single_gnt", 32'(gnt), 32'b0100);
        check("single_data", 32'(spi_data), 32'hA5);
        req = '0;
        tick();
        check("single_start_pulse", 32'(spi_start), 32'd0);
        tick();
        spi_done = 1'b1; spi_rx = 8'h3C;
        tick();
        check("single_rsp", 32'(rsp_valid), 32'b0100);
        check("single_rx", 32'(rx_data), 32'h3C);
        check("single_err", 32'(err), 32'd0);
        check("single_gnt_drop", 32'(gnt), 32'd0);
        spi_done = 1'b0;
        tick();
        check("single_rsp_pulse", 32'(rsp_valid), 32'd0);
        wait_idle();

        // Round robin with all requesters asking, starting from pointer 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(s_at[i]);
            check("rr_gnt", 32'(gnt), 32'(1 << rr_exp[i]));
            if (i > 0) check("rr_spacing", 32'(s_at[i] - s_at[i-1]), 32'(GAP + 3));
            if (i == 4) req = '0;
            tick();
            spi_done = 1'b1;
            tick();
            spi_done = 1'b0;
        end
        wait_idle();

        // Stale done level must not complete; only the later rising edge does.
        req = 4'b0001; spi_done = 1'b1;
        tick();
        check("stale_gnt", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check("stale_w1_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("stale_w2_rsp", 32'(rsp_valid), 32'd0);
        spi_done = 1'b0;
        tick();
        check("stale_w3_rsp", 32'(rsp_valid), 32'd0);
        check("stale_w3_gnt", 32'(gnt), 32'b0001);
        spi_done = 1'b1; spi_rx = 8'h5A;
        tick();
        check("stale_rsp", 32'(rsp_valid), 32'b0001);
        check("stale_rx", 32'(rx_data), 32'h5A);
        spi_done = 1'b0;
        wait_idle();

        // Timeout: no done edge at all.
        req = 4'b0010;
        wait_start(s);
        req = '0;
        n = 0;
        while (rsp_valid === '0 && n < 100) begin
            tick();
            n++;
        end
        r = cyc;
        check("to_latency", 32'(r - s), 32'(TO + 1));
        check("to_rsp", 32'(rsp_valid), 32'b0010);
        check("to_err", 32'(err), 32'd1);
        check("to_rx", 32'(rx_data), 32'h00);
        tick();
        check("to_err_pulse", 32'(err), 32'd0);
        check("to_gap_busy", 32'(busy), 32'd1);
        tick();
        check("to_idle", 32'(busy), 32'd0);

        // Reset in the middle of WAIT, then arbitration restarts at pointer 0.
        req = 4'b0100;
        wait_start(s);
        req = '0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst_n = 1'b1; req = 4'b1010;
        tick();
        check("midrst_gnt", 32'(gnt), 32'b0010);
        check("midrst_data", 32'(spi_data), 32'h22);
        req = '0;
        tick();
        spi_done = 1'b1; spi_rx = 8'h77;
        tick();
        check("midrst_rsp", 32'(rsp_valid), 32'b0010);
        check("midrst_rx", 32'(rx_data), 32'h77);
        spi_done = 1'b0;
        wait_idle();

        // Requester withdraws right after its grant; transfer still completes.
        req = 4'b1000;
        wait_start(s);
        check("wd_gnt", 32'(gnt), 32'b1000);
        check("wd_data", 32'(spi_data), 32'h44);
        req = '0;
        tick(); tick(); tick();
        check("wd_pending", 32'(rsp_valid), 32'd0);
        spi_done = 1'b1; spi_rx = 8'hC3;
        tick();
        check("wd_rsp", 32'(rsp_valid), 32'b1000);
        check("wd_rx", 32'(rx_data), 32'hC3);
        check("wd_err", 32'(err), 32'd0);
        spi_done = 1'b0;
        wait_idle();

        // Done edge on the very last WAIT cycle wins over the timeout.
        req = 4'b0001;
        wait_start(s);
        req = '0;
        for (int i = 0; i < TO; i++) tick();
        spi_done = 1'b1; spi_rx = 8'h99;
        tick();
        check("edge_rsp", 32'(rsp_valid), 32'b0001);
        check("edge_err", 32'(err), 32'd0);
        check("edge_rx", 32'(rx_data), 32'h99);
        spi_done = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SPI master (2..8).
REQ-002 Parameter GAP_CYCLES, default 2: minimum idle cycles between transactions (1..15).
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort (16..1023).
REQ-004 clk  in  1  rising-edge clock for all logic.
REQ-005 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-006 req  in  NUM_REQ  per-requester transaction request, level.
REQ-007 tx_data  in  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-008 gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-009 rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 rx_data  out  8  received byte, valid when any rsp_valid bit is 1.
REQ-011 err  out  1  one-cycle pulse coincident with rsp_valid on timeout abort.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 spi_start  out  1  start strobe to SPI master.
REQ-014 spi_data  out  8  byte to SPI master, stable from START until the next grant.
REQ-015 spi_done  in  1  SPI master done level (stays high until the next start).
REQ-016 spi_rx  in  8  SPI master received byte.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, GAP; all outputs SHALL be registered.
REQ-018 IDLE: if any req bit is 1, the winner SHALL be the first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0; the next state is START.
REQ-019 On entering START: gnt[winner]=1, spi_data=tx_data slice of winner, spi_start=1, rr_ptr=(winner+1) mod NUM_REQ.
REQ-020 spi_start SHALL be high for exactly one cycle (the START cycle); START -> WAIT unconditionally.
REQ-021 done_q SHALL register spi_done every cycle; completion is spi_done=1 and done_q=0 while in WAIT (rising edge only).
REQ-022 A spi_done level already high on WAIT entry (stale from previous transfer) SHALL NOT count as completion.
REQ-023 WAIT: the timeout counter SHALL reset to 0 on WAIT entry and increment each WAIT cycle, saturating.
REQ-024 On completion: the next cycle has rsp_valid[winner]=1, rx_data=spi_rx, err=0, gnt=0, state GAP.
REQ-025 If the counter reaches TIMEOUT-1 without completion: the next cycle has rsp_valid[winner]=1, rx_data=8'h00, err=1, gnt=0, state GAP.
REQ-026 Completion and timeout in the same cycle SHALL be treated as completion (err=0).
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; req is ignored during GAP.
REQ-028 req is sampled only in IDLE; deasserting req after grant SHALL NOT abort the transaction.
REQ-029 Minimum latency: req high in IDLE cycle N -> spi_start in cycle N+1 -> rsp_valid one cycle after the done edge.
REQ-030 gnt and rsp_valid SHALL each be zero or one-hot at all times.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rx_data=8'h00, err=0, busy=0, spi_start=0, spi_data=8'h00, done_q=0, and clear the counters.
REQ-032 A reset mid-transaction SHALL abandon it with no rsp_valid pulse; the first request after reset is arbitrated from rr_ptr=0.

Verification
REQ-033 Single request: req=4'b0100, tx_data slice 2=8'hA5, done edge with spi_rx=8'h3C -> one spi_start pulse, spi_data=8'hA5, gnt=4'b0100, rsp_valid=4'b0100 with rx_data=8'h3C, err=0.
REQ-034 Round robin: req=4'b1111 held -> grants in order 0,1,2,3,0; successive spi_start pulses separated by at least GAP_CYCLES+3 cycles.
REQ-035 Stale done: spi_done held at 1 through START and into WAIT, then 0, then 1 -> completion only on the later rising edge.
REQ-036 Timeout: spi_done held at 0 -> after TIMEOUT WAIT cycles, rsp_valid and err=1 pulse together, rx_data=8'h00, then GAP, then IDLE.
REQ-037 Reset mid-WAIT: rst_n=0 for one cycle -> all outputs at reset values the next cycle, no rsp_valid; req=4'b1010 -> requester 1 is granted first.
REQ-038 Requester withdrawal: req drops the cycle after grant -> the transaction still completes with a normal rsp_valid pulse.
